// File: rtl/wishbone_slave_decoder.sv
// Routes the granted Wishbone master cycle to one of NSLV slaves by address,
// with registered strobes/responses, unmapped-slave errors and a wait timeout.
module wishbone_slave_decoder #(
  parameter int              AW      = 32,
  parameter int              DW      = 32,
  parameter int              NSLV    = 4,
  parameter int              SEL_MSB = 31,
  parameter logic [NSLV-1:0] SLV_EN  = 4'hF,
  parameter int              TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 m_cyc_i,
  input  logic                 m_stb_i,
  input  logic                 m_we_i,
  input  logic [AW-1:0]        m_adr_i,
  input  logic [DW-1:0]        m_dat_i,
  input  logic [DW/8-1:0]      m_sel_i,
  output logic [DW-1:0]        m_dat_o,
  output logic                 m_ack_o,
  output logic                 m_err_o,
  output logic [NSLV-1:0]      s_cyc_o,
  output logic [NSLV-1:0]      s_stb_o,
  output logic                 s_we_o,
  output logic [AW-1:0]        s_adr_o,
  output logic [DW-1:0]        s_dat_o,
  output logic [DW/8-1:0]      s_sel_o,
  input  logic [NSLV*DW-1:0]   s_dat_i,
  input  logic [NSLV-1:0]      s_ack_i,
  input  logic [NSLV-1:0]      s_err_i,
  input  logic                 scan_in0,
  input  logic                 scan_enable,
  input  logic                 test_mode,
  output logic                 scan_out0
);

  localparam int          SW     = DW / 8;
  localparam int          IW     = $clog2(NSLV);
  localparam logic [15:0] TO_CNT = 16'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ACTIVE, RESP, ERR} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   idx, idx_nxt, req_idx;
  logic [15:0]     count, count_nxt;
  logic            req, latch;
  logic            sel_ack, sel_err, timed_out;
  logic [DW-1:0]   sel_dat;
  logic            ack_nxt, err_nxt;
  logic [DW-1:0]   dat_nxt;
  logic [NSLV-1:0] strb_nxt;

  // No scan chain is stitched here; the DFT pins only feed a benign AND.
  assign scan_out0 = scan_in0 & scan_enable & test_mode;

  assign req       = m_cyc_i & m_stb_i;
  assign req_idx   = m_adr_i[SEL_MSB -: IW];
  assign sel_ack   = s_ack_i[idx];
  assign sel_err   = s_err_i[idx];
  assign sel_dat   = s_dat_i[int'(idx)*DW +: DW];
  assign timed_out = (count == TO_CNT);

  // State and output registers; the whole bus side clears on reset so an
  // aborted cycle can never produce a late ack or err.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      idx     <= '0;
      count   <= '0;
      m_ack_o <= 1'b0;
      m_err_o <= 1'b0;
      m_dat_o <= '0;
      s_cyc_o <= '0;
      s_stb_o <= '0;
      s_we_o  <= 1'b0;
      s_adr_o <= '0;
      s_dat_o <= '0;
      s_sel_o <= '0;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      count   <= count_nxt;
      m_ack_o <= ack_nxt;
      m_err_o <= err_nxt;
      m_dat_o <= dat_nxt;
      s_cyc_o <= strb_nxt;
      s_stb_o <= strb_nxt;
      if (latch) begin
        s_we_o  <= m_we_i;
        s_adr_o <= m_adr_i;
        s_dat_o <= m_dat_i;
        s_sel_o <= m_sel_i;
      end
    end
  end

  // Next-state logic; an abort by the master outranks any slave response.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req) state_nxt = SLV_EN[req_idx] ? ACTIVE : ERR;
      ACTIVE: begin
        if (!m_cyc_i)                             state_nxt = IDLE;
        else if (sel_err || sel_ack || timed_out) state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: next values for the registered bus signals.
  always_comb begin
    latch     = 1'b0;
    ack_nxt   = 1'b0;
    err_nxt   = 1'b0;
    dat_nxt   = m_dat_o;
    count_nxt = '0;
    case (state)
      IDLE: begin
        if (req) begin
          latch = 1'b1;
          if (!SLV_EN[req_idx]) begin
            err_nxt = 1'b1;
            dat_nxt = '0;
          end
        end
      end
      ACTIVE: begin
        count_nxt = count + 16'd1;
        if (m_cyc_i) begin
          if (sel_err) begin
            err_nxt = 1'b1;
            dat_nxt = '0;
          end else if (sel_ack) begin
            ack_nxt = 1'b1;
            dat_nxt = sel_dat;
          end else if (timed_out) begin
            err_nxt = 1'b1;
            dat_nxt = '0;
          end
        end
      end
      default: ;
    endcase
    idx_nxt  = latch ? req_idx : idx;
    strb_nxt = (state_nxt == ACTIVE) ? (NSLV'(1) << idx_nxt) : '0;
  end

endmodule

// File: tb/tb_wishbone_slave_decoder.sv
// Bench for wishbone_slave_decoder: two instances (full map / partial map)
// share one master and one set of slaves; expected responses go through a queue.
module tb_wishbone_slave_decoder;

  logic         clk = 1'b0;
  logic         reset;
  logic         m_cyc_i, m_stb_i, m_we_i;
  logic [31:0]  m_adr_i, m_dat_i;
  logic [3:0]   m_sel_i;
  logic [127:0] s_dat_i;
  logic [3:0]   s_ack_i, s_err_i;
  logic         scan_in0, scan_enable, test_mode;

  logic [31:0]  a_m_dat_o, b_m_dat_o, a_s_adr_o, b_s_adr_o, a_s_dat_o, b_s_dat_o;
  logic         a_m_ack_o, b_m_ack_o, a_m_err_o, b_m_err_o, a_s_we_o, b_s_we_o;
  logic [3:0]   a_s_cyc_o, b_s_cyc_o, a_s_stb_o, b_s_stb_o, a_s_sel_o, b_s_sel_o;
  logic         a_scan_out0, b_scan_out0;

  typedef struct packed {
    logic        err;
    logic [31:0] dat;
  } exp_t;
  exp_t exp_q[$];
  exp_t e;

  int errors = 0;
  int checks = 0;

  localparam logic [31:0] D0 = 32'h0000_0B00;
  localparam logic [31:0] D1 = 32'h1111_0001;
  localparam logic [31:0] D2 = 32'h2222_0002;
  localparam logic [31:0] D3 = 32'hCAFE_F00D;

  always #5 clk = ~clk;

  wishbone_slave_decoder #(.TIMEOUT(8)) dut_a (
    .clk(clk), .reset(reset), .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i), .m_dat_o(a_m_dat_o),
    .m_ack_o(a_m_ack_o), .m_err_o(a_m_err_o), .s_cyc_o(a_s_cyc_o), .s_stb_o(a_s_stb_o),
    .s_we_o(a_s_we_o), .s_adr_o(a_s_adr_o), .s_dat_o(a_s_dat_o), .s_sel_o(a_s_sel_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .scan_in0(scan_in0),
    .scan_enable(scan_enable), .test_mode(test_mode), .scan_out0(a_scan_out0));

  wishbone_slave_decoder #(.SLV_EN(4'b0111)) dut_b (
    .clk(clk), .reset(reset), .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i), .m_dat_o(b_m_dat_o),
    .m_ack_o(b_m_ack_o), .m_err_o(b_m_err_o), .s_cyc_o(b_s_cyc_o), .s_stb_o(b_s_stb_o),
    .s_we_o(b_s_we_o), .s_adr_o(b_s_adr_o), .s_dat_o(b_s_dat_o), .s_sel_o(b_s_sel_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .scan_in0(scan_in0),
    .scan_enable(scan_enable), .test_mode(test_mode), .scan_out0(b_scan_out0));

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Present a request for exactly one edge; returns in cycle 1 with m_cyc_i still high.
  task automatic start_req(input logic we, input logic [31:0] adr, input logic [31:0] dat);
    m_cyc_i = 1'b1; m_stb_i = 1'b1; m_we_i = we;
    m_adr_i = adr;  m_dat_i = dat;  m_sel_i = 4'hF;
    cyc();
    m_stb_i = 1'b0;
  endtask

  task automatic idle_bus();
    m_cyc_i = 1'b0; m_stb_i = 1'b0; s_ack_i = '0; s_err_i = '0;
    cyc();
    cyc();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc();
    cyc();
    checks++;
    if ({a_m_ack_o, a_m_err_o, a_m_dat_o} !== 34'd0) begin
      errors++; $display("FAIL reset_resp: got %h want 0", {a_m_ack_o, a_m_err_o, a_m_dat_o});
    end
    checks++;
    if ({a_s_cyc_o, a_s_stb_o, b_s_cyc_o, b_s_stb_o} !== 16'd0) begin
      errors++; $display("FAIL reset_strobes: got %h want 0", {a_s_cyc_o, a_s_stb_o, b_s_cyc_o, b_s_stb_o});
    end
    checks++;
    if ({a_s_we_o, a_s_adr_o, a_s_dat_o, a_s_sel_o} !== 69'd0) begin
      errors++; $display("FAIL reset_shared: got %h want 0", {a_s_we_o, a_s_adr_o, a_s_dat_o, a_s_sel_o});
    end
    reset = 1'b0;
    cyc();
  endtask

  task automatic test_write_zero_wait();
    exp_q.push_back('{err: 1'b0, dat: D1});
    start_req(1'b1, 32'h4000_0010, 32'hA5A5_1234);
    checks++;
    if ({a_s_cyc_o, a_s_stb_o} !== 8'b0010_0010) begin
      errors++; $display("FAIL write_strobe: got %b want 00100010", {a_s_cyc_o, a_s_stb_o});
    end
    checks++;
    if ({a_s_we_o, a_s_adr_o, a_s_dat_o, a_s_sel_o} !== {1'b1, 32'h4000_0010, 32'hA5A5_1234, 4'hF}) begin
      errors++; $display("FAIL write_shared: got %h want %h",
        {a_s_we_o, a_s_adr_o, a_s_dat_o, a_s_sel_o}, {1'b1, 32'h4000_0010, 32'hA5A5_1234, 4'hF});
    end
    checks++;
    if (a_m_ack_o !== 1'b0) begin
      errors++; $display("FAIL write_early_ack: got %b want 0", a_m_ack_o);
    end
    s_ack_i = 4'b0010;
    cyc();
    s_ack_i = '0;
    e = exp_q.pop_front();
    checks++;
    if ({a_m_ack_o, a_m_err_o, a_m_dat_o} !== {~e.err, e.err, e.dat}) begin
      errors++; $display("FAIL write_ack: got %h want %h", {a_m_ack_o, a_m_err_o, a_m_dat_o}, {~e.err, e.err, e.dat});
    end
    checks++;
    if (a_s_stb_o !== 4'b0000) begin
      errors++; $display("FAIL write_strobe_drop: got %b want 0000", a_s_stb_o);
    end
    cyc();
    checks++;
    if (a_m_ack_o !== 1'b0) begin
      errors++; $display("FAIL write_ack_width: got %b want 0", a_m_ack_o);
    end
    idle_bus();
  endtask

  task automatic test_unmapped();
    exp_q.push_back('{err: 1'b1, dat: 32'd0});
    start_req(1'b0, 32'hC000_0000, 32'd0);
    checks++;
    if ({b_s_cyc_o, b_s_stb_o} !== 8'd0) begin
      errors++; $display("FAIL unmapped_strobe: got %b want 0", {b_s_cyc_o, b_s_stb_o});
    end
    e = exp_q.pop_front();
    checks++;
    if ({b_m_ack_o, b_m_err_o, b_m_dat_o} !== {~e.err, e.err, e.dat}) begin
      errors++; $display("FAIL unmapped_err: got %h want %h", {b_m_ack_o, b_m_err_o, b_m_dat_o}, {~e.err, e.err, e.dat});
    end
    cyc();
    checks++;
    if ({b_m_err_o, b_s_stb_o} !== 5'd0) begin
      errors++; $display("FAIL unmapped_err_width: got %b want 0", {b_m_err_o, b_s_stb_o});
    end
    idle_bus();
  endtask

  task automatic test_read_wait();
    exp_q.push_back('{err: 1'b0, dat: D3});
    start_req(1'b0, 32'hC000_0020, 32'd0);
    for (int c = 1; c <= 5; c++) cyc();
    checks++;
    if ({a_s_stb_o, a_m_ack_o} !== 5'b1000_0) begin
      errors++; $display("FAIL read_wait_state: got %b want 10000", {a_s_stb_o, a_m_ack_o});
    end
    s_ack_i = 4'b1000;
    cyc();
    s_ack_i = '0;
    e = exp_q.pop_front();
    checks++;
    if ({a_m_ack_o, a_m_err_o, a_m_dat_o} !== {~e.err, e.err, e.dat}) begin
      errors++; $display("FAIL read_ack_cycle7: got %h want %h", {a_m_ack_o, a_m_err_o, a_m_dat_o}, {~e.err, e.err, e.dat});
    end
    cyc();
    checks++;
    if ({a_m_ack_o, a_m_dat_o} !== {1'b0, D3}) begin
      errors++; $display("FAIL read_hold: got %h want %h", {a_m_ack_o, a_m_dat_o}, {1'b0, D3});
    end
    idle_bus();
  endtask

  task automatic test_timeout();
    int strobes = 0;
    int errs    = 0;
    int err_cyc = 0;
    logic [32:0] resp = '0;
    exp_q.push_back('{err: 1'b1, dat: 32'd0});
    start_req(1'b0, 32'h8000_0000, 32'd0);
    for (int i = 0; i < 20; i++) begin
      if (a_s_stb_o == 4'b0100) strobes++;
      if (a_m_err_o) begin
        errs++;
        err_cyc = i + 1;
        resp = {a_m_ack_o, a_m_dat_o};
      end
      cyc();
    end
    checks++;
    if (strobes != 9) begin
      errors++; $display("FAIL timeout_strobe_cycles: got %0d want 9", strobes);
    end
    checks++;
    if (errs != 1 || err_cyc != 10) begin
      errors++; $display("FAIL timeout_err_pulse: got %0d pulses at cycle %0d want 1 at cycle 10", errs, err_cyc);
    end
    e = exp_q.pop_front();
    checks++;
    if (resp !== {1'b0, e.dat}) begin
      errors++; $display("FAIL timeout_resp: got %h want %h", resp, {1'b0, e.dat});
    end
    m_cyc_i = 1'b0;
    cyc();
    exp_q.push_back('{err: 1'b0, dat: D0});
    start_req(1'b1, 32'h0000_0040, 32'h0BAD_CAFE);
    checks++;
    if (a_s_stb_o !== 4'b0001) begin
      errors++; $display("FAIL timeout_next_strobe: got %b want 0001", a_s_stb_o);
    end
    s_ack_i = 4'b0001;
    cyc();
    s_ack_i = '0;
    e = exp_q.pop_front();
    checks++;
    if ({a_m_ack_o, a_m_err_o, a_m_dat_o} !== {~e.err, e.err, e.dat}) begin
      errors++; $display("FAIL timeout_next_ack: got %h want %h", {a_m_ack_o, a_m_err_o, a_m_dat_o}, {~e.err, e.err, e.dat});
    end
    idle_bus();
  endtask

  task automatic test_err_beats_ack();
    exp_q.push_back('{err: 1'b1, dat: 32'd0});
    start_req(1'b0, 32'h4000_0000, 32'd0);
    s_ack_i = 4'b0001;
    s_err_i = 4'b0100;
    cyc();
    checks++;
    if ({a_m_ack_o, a_m_err_o, a_s_stb_o} !== 6'b00_0010) begin
      errors++; $display("FAIL other_slave_ignored: got %b want 000010", {a_m_ack_o, a_m_err_o, a_s_stb_o});
    end
    s_ack_i = 4'b0010;
    s_err_i = 4'b0010;
    cyc();
    s_ack_i = '0;
    s_err_i = '0;
    e = exp_q.pop_front();
    checks++;
    if ({a_m_ack_o, a_m_err_o, a_m_dat_o} !== {~e.err, e.err, e.dat}) begin
      errors++; $display("FAIL err_beats_ack: got %h want %h", {a_m_ack_o, a_m_err_o, a_m_dat_o}, {~e.err, e.err, e.dat});
    end
    idle_bus();
  endtask

  task automatic test_abort();
    int resp = 0;
    start_req(1'b0, 32'h4000_0000, 32'd0);
    cyc();
    m_cyc_i = 1'b0;
    cyc();
    checks++;
    if ({a_s_cyc_o, a_s_stb_o} !== 8'd0) begin
      errors++; $display("FAIL abort_strobe: got %b want 0", {a_s_cyc_o, a_s_stb_o});
    end
    s_ack_i = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      if (a_m_ack_o || a_m_err_o) resp++;
      cyc();
    end
    checks++;
    if (resp != 0) begin
      errors++; $display("FAIL abort_no_resp: got %0d responses want 0", resp);
    end
    idle_bus();
  endtask

  task automatic test_reset_mid();
    int resp = 0;
    start_req(1'b1, 32'h4000_0004, 32'h1234_5678);
    cyc();
    reset = 1'b1;
    m_cyc_i = 1'b0;
    cyc();
    checks++;
    if ({a_s_cyc_o, a_s_stb_o, a_m_ack_o, a_m_err_o, a_m_dat_o, a_s_we_o, a_s_adr_o, a_s_dat_o, a_s_sel_o} !== 111'd0) begin
      errors++; $display("FAIL reset_mid_outputs: got %h want 0",
        {a_s_cyc_o, a_s_stb_o, a_m_ack_o, a_m_err_o, a_m_dat_o, a_s_we_o, a_s_adr_o, a_s_dat_o, a_s_sel_o});
    end
    reset = 1'b0;
    s_ack_i = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (a_m_ack_o || a_m_err_o) resp++;
    end
    checks++;
    if (resp != 0) begin
      errors++; $display("FAIL reset_stale_ack: got %0d responses want 0", resp);
    end
    idle_bus();
  endtask

  task automatic test_back_to_back();
    exp_q.push_back('{err: 1'b0, dat: D0});
    start_req(1'b1, 32'h0000_0100, 32'h1);
    s_ack_i = 4'b0001;
    cyc();
    s_ack_i = '0;
    e = exp_q.pop_front();
    checks++;
    if ({a_m_ack_o, a_m_err_o, a_m_dat_o} !== {~e.err, e.err, e.dat}) begin
      errors++; $display("FAIL b2b_first: got %h want %h", {a_m_ack_o, a_m_err_o, a_m_dat_o}, {~e.err, e.err, e.dat});
    end
    cyc();
    exp_q.push_back('{err: 1'b0, dat: D1});
    start_req(1'b1, 32'h4000_0100, 32'h2);
    checks++;
    if ({a_s_stb_o, a_m_ack_o} !== 5'b0010_0) begin
      errors++; $display("FAIL b2b_second_strobe: got %b want 00100", {a_s_stb_o, a_m_ack_o});
    end
    s_ack_i = 4'b0010;
    cyc();
    s_ack_i = '0;
    e = exp_q.pop_front();
    checks++;
    if ({a_m_ack_o, a_m_err_o, a_m_dat_o} !== {~e.err, e.err, e.dat}) begin
      errors++; $display("FAIL b2b_second: got %h want %h", {a_m_ack_o, a_m_err_o, a_m_dat_o}, {~e.err, e.err, e.dat});
    end
    idle_bus();
  endtask

  initial begin
    reset = 1'b1;
    m_cyc_i = 1'b0; m_stb_i = 1'b0; m_we_i = 1'b0;
    m_adr_i = '0; m_dat_i = '0; m_sel_i = '0;
    s_dat_i = {D3, D2, D1, D0};
    s_ack_i = '0; s_err_i = '0;
    scan_in0 = 1'b0; scan_enable = 1'b0; test_mode = 1'b0;
    #1;
    test_reset();
    test_write_zero_wait();
    test_unmapped();
    test_read_wait();
    test_timeout();
    test_err_beats_ack();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_leftover: got %0d entries want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion want finish before 100000");
    $fatal(1, "watchdog expired");
  end

endmodule
